// File: rtl/tl_monitor_if.sv
// Light bus seen by the traffic-light monitor, plus the decoded status it reports.
interface tl_monitor_if #(
   parameter int unsigned CNT_W = 8
) ();
   logic [2:0]       leds;
   logic             err_clr;
   logic [2:0]       phase;
   logic             phase_done;
   logic [2:0]       last_phase;
   logic [CNT_W-1:0] phase_len;
   logic [2:0]       err;

   modport master (
      output leds, err_clr,
      input  phase, phase_done, last_phase, phase_len, err
   );

   modport slave (
      input  leds, err_clr,
      output phase, phase_done, last_phase, phase_len, err
   );
endinterface

// File: rtl/tl_monitor.sv
// Passive checker on the traffic_light leds bus: decodes phases, measures their
// length in cycles and flags illegal codes, illegal ordering and timing violations.
module tl_monitor #(
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned YELLOW_CYC    = 7,
   parameter int unsigned RED_CYC       = 5,
   parameter int unsigned GREEN_MIN_CYC = 61,
   parameter int unsigned GREEN_MAX_CYC = 121
) (
   input  logic          clk,
   input  logic          rst,
   tl_monitor_if.slave   bus
);

   typedef enum logic [2:0] {
      PH_OFF     = 3'd0,
      PH_GREEN   = 3'd1,
      PH_YELLOW  = 3'd2,
      PH_RED     = 3'd3,
      PH_ILLEGAL = 3'd4
   } phase_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   phase_e           d_c;
   phase_e           phase_q;
   phase_e           last_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] len_q;
   logic             done_q;
   logic             checked_q;
   logic [2:0]       err_q;

   logic             end_c;
   logic             illegal_c;
   logic             order_c;
   logic             timing_c;
   logic [2:0]       set_c;

   // Bus decode: exactly one lamp lit, or all dark; anything else is illegal.
   always_comb begin
      d_c = PH_ILLEGAL;
      case (bus.leds)
         3'b000:  d_c = PH_OFF;
         3'b100:  d_c = PH_GREEN;
         3'b010:  d_c = PH_YELLOW;
         3'b001:  d_c = PH_RED;
         default: d_c = PH_ILLEGAL;
      endcase
   end

   // Error events for this cycle; last_q doubles as the phase the current one was entered from.
   always_comb begin
      end_c     = (d_c != phase_q);
      illegal_c = (d_c == PH_ILLEGAL) || (phase_q == PH_ILLEGAL);
      order_c   = end_c && (((phase_q == PH_YELLOW) && (d_c == PH_GREEN)) ||
                            ((phase_q == PH_RED)    && (d_c == PH_YELLOW)));
      timing_c  = 1'b0;
      if (end_c && checked_q) begin
         case (phase_q)
            PH_YELLOW: timing_c = (last_q == PH_GREEN) &&
                                  (cnt_q != CNT_W'(YELLOW_CYC));
            PH_RED:    timing_c = (d_c == PH_GREEN) &&
                                  (cnt_q < CNT_W'(RED_CYC));
            PH_GREEN:  timing_c = (d_c == PH_YELLOW) &&
                                  ((cnt_q < CNT_W'(GREEN_MIN_CYC)) ||
                                   (cnt_q > CNT_W'(GREEN_MAX_CYC)));
            default:   timing_c = 1'b0;
         endcase
      end
      set_c = {timing_c, order_c, illegal_c};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q   <= PH_OFF;
         last_q    <= PH_OFF;
         cnt_q     <= '0;
         len_q     <= '0;
         done_q    <= 1'b0;
         checked_q <= 1'b0;
         err_q     <= 3'b000;
      end else begin
         done_q <= end_c;
         // A fresh error event wins over a simultaneous clear.
         err_q  <= (err_q & {3{~bus.err_clr}}) | set_c;
         if (end_c) begin
            phase_q   <= d_c;
            last_q    <= phase_q;
            len_q     <= cnt_q;
            cnt_q     <= CNT_W'(1);
            checked_q <= phase_q inside {PH_GREEN, PH_YELLOW, PH_RED};
         end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.phase      = phase_q;
   assign bus.phase_done = done_q;
   assign bus.last_phase = last_q;
   assign bus.phase_len  = len_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_tl_monitor.sv
// Randomized and directed bench for tl_monitor: a segment-level model predicts each
// phase report and the sticky error bits; a negedge monitor pops and compares.
module tb_tl_monitor;

   localparam int unsigned CNT_W = 8;
   localparam int          MAXC  = 255;
   localparam int          YC    = 7;
   localparam int          RC    = 5;
   localparam int          GMIN  = 61;
   localparam int          GMAX  = 121;

   localparam logic [2:0] P_OFF = 3'd0;
   localparam logic [2:0] P_G   = 3'd1;
   localparam logic [2:0] P_Y   = 3'd2;
   localparam logic [2:0] P_R   = 3'd3;
   localparam logic [2:0] P_ILL = 3'd4;

   typedef struct {
      logic [2:0] last;
      int         len;
      logic [2:0] err;
      logic [2:0] ph;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   exp_t       sb[$];
   logic [2:0] m_phase;
   logic [2:0] m_from;
   int         m_len;
   logic [2:0] m_err;

   tl_monitor_if #(.CNT_W(CNT_W)) bus ();

   tl_monitor #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] dec(input logic [2:0] v);
      case (v)
         3'b000:  return P_OFF;
         3'b100:  return P_G;
         3'b010:  return P_Y;
         3'b001:  return P_R;
         default: return P_ILL;
      endcase
   endfunction

   function automatic int sat(input int l);
      return (l > MAXC) ? MAXC : l;
   endfunction

   // Error bits raised when phase p (length l, entered from f) is replaced by q.
   function automatic logic [2:0] events(input logic [2:0] p, input logic [2:0] q,
                                         input int l, input logic [2:0] f);
      logic e0, e1, e2, checked;
      e0      = (q == P_ILL) || (p == P_ILL);
      e1      = ((p == P_Y) && (q == P_G)) || ((p == P_R) && (q == P_Y));
      checked = (f == P_G) || (f == P_Y) || (f == P_R);
      e2      = checked && (((p == P_Y) && (f == P_G) && (l != YC)) ||
                            ((p == P_R) && (q == P_G) && (l < RC)) ||
                            ((p == P_G) && (q == P_Y) && ((l < GMIN) || (l > GMAX))));
      return {e2, e1, e0};
   endfunction

   // Hold leds=v for n sampling edges; optional err_clr pulse on edge clr_at.
   task automatic drive_seg(input logic [2:0] v, input int n, input int clr_at);
      logic [2:0] q;
      logic [2:0] ev;
      bit         bnd;
      q   = dec(v);
      bnd = (q != m_phase);
      ev  = bnd ? events(m_phase, q, sat(m_len), m_from) : 3'b000;
      if (clr_at == 0) m_err = bnd ? ev : ((q == P_ILL) ? 3'b001 : 3'b000);
      else             m_err = m_err | ev;
      if (bnd) begin
         sb.push_back('{last: m_phase, len: sat(m_len), err: m_err, ph: q});
         m_from  = m_phase;
         m_phase = q;
         m_len   = n;
      end else begin
         m_len = m_len + n;
      end
      bus.leds = v;
      for (int i = 0; i < n; i++) begin
         bus.err_clr = (i == clr_at);
         @(posedge clk);
         #1;
         if (i == clr_at) begin
            if (i > 0) m_err = (q == P_ILL) ? 3'b001 : 3'b000;
            chk("err_after_clr", 32'(bus.err), 32'(m_err));
         end
      end
      bus.err_clr = 1'b0;
   endtask

   task automatic model_reset();
      sb.delete();
      m_phase = P_OFF;
      m_from  = P_OFF;
      m_len   = 0;
      m_err   = 3'b000;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_phase"}, 32'(bus.phase), 0);
      chk({tag, "_done"},  32'(bus.phase_done), 0);
      chk({tag, "_last"},  32'(bus.last_phase), 0);
      chk({tag, "_len"},   32'(bus.phase_len), 0);
      chk({tag, "_err"},   32'(bus.err), 0);
   endtask

   // Reset asserted between edges; outputs must clear before the next posedge.
   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && bus.phase_done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(bus.phase_done), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("last_phase", 32'(bus.last_phase), 32'(e.last));
            chk("phase_len",  32'(bus.phase_len),  32'(e.len));
            chk("err",        32'(bus.err),        32'(e.err));
            chk("new_phase",  32'(bus.phase),      32'(e.ph));
         end
      end
   end

   function automatic logic [2:0] rand_illegal();
      case ($urandom_range(0, 3))
         0:       return 3'b011;
         1:       return 3'b101;
         2:       return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   initial begin
      int r, n, c;
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.leds    = 3'b000;
      bus.err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_zero("reset");
      rst = 1'b0;

      // Nominal cycle
      drive_seg(3'b100, 61, -1);
      drive_seg(3'b010, YC, -1);
      drive_seg(3'b001, RC, -1);
      // Short yellow, then clear the timing error
      drive_seg(3'b100, 61, -1);
      drive_seg(3'b010, 6, -1);
      drive_seg(3'b001, 5, 1);
      // Illegal glitch mid-green
      drive_seg(3'b100, 20, -1);
      drive_seg(3'b110, 1, -1);
      drive_seg(3'b100, 30, -1);
      drive_seg(3'b010, YC, -1);
      // Order errors, yellow entered from red is untimed
      drive_seg(3'b001, RC, 2);
      drive_seg(3'b010, 61, -1);
      drive_seg(3'b100, 61, -1);
      // Saturated green still violates the maximum
      drive_seg(3'b001, RC, 0);
      drive_seg(3'b100, 300, -1);
      drive_seg(3'b010, YC, -1);
      drive_seg(3'b001, RC, -1);
      // Force-red and attention blink
      async_reset();
      drive_seg(3'b100, 2, -1);
      drive_seg(3'b001, 5, -1);
      for (int k = 0; k < 2; k++) begin
         drive_seg(3'b000, 3, -1);
         drive_seg(3'b010, 3, -1);
      end
      drive_seg(3'b000, 3, -1);
      // Reset during yellow, then clear colliding with an illegal code
      drive_seg(3'b100, 61, -1);
      drive_seg(3'b010, 3, -1);
      async_reset();
      drive_seg(3'b011, 2, 0);
      drive_seg(3'b000, 3, -1);

      // Randomized segments
      for (int k = 0; k < 120; k++) begin
         r = $urandom_range(0, 9);
         c = ($urandom_range(0, 7) == 0) ? 0 : -1;
         case (r)
            0, 1, 2: begin
               n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : $urandom_range(58, 125);
               drive_seg(3'b100, n, c);
            end
            3, 4: begin
               n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 9);
               drive_seg(3'b010, n, c);
            end
            5, 6: drive_seg(3'b001, $urandom_range(3, 8), c);
            7:    drive_seg(3'b000, $urandom_range(1, 4), c);
            8:    drive_seg(rand_illegal(), $urandom_range(1, 3), c);
            default: begin
               drive_seg(3'b100, $urandom_range(GMIN, GMAX), -1);
               drive_seg(3'b010, YC, -1);
               n = $urandom_range(1, 4);
               drive_seg(3'b001, $urandom_range(RC, 8), (c == 0) ? n - 1 : -1);
            end
         endcase
      end

      drive_seg(3'b000, 3, -1);
      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", 32'(sb.size()), 0);
      chk("final_err", 32'(bus.err), 32'(m_err));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_monitor.md
Name: tl_monitor

Overview:
Passive checker on the traffic_light `leds` output bus (100 green, 010 yellow, 001 red, 000 off).
- Decodes the bus into phases and measures each phase length in clock cycles (1 cycle = 0.5 s).
- Flags illegal encodings, illegal phase order and out-of-spec yellow/red/green durations.
- Sits beside traffic_light at top level, feeding status/fault logic.
- Never drives the light.

Parameters:
CNT_W, 8, width of the phase-length counter; saturates at 2^CNT_W-1.
YELLOW_CYC, 7, required exact yellow length in cycles when yellow is entered from green.
RED_CYC, 5, minimum red length in cycles when red is entered from yellow or green.
GREEN_MIN_CYC, 61, minimum green length when green exits to yellow.
GREEN_MAX_CYC, 121, maximum green length when green exits to yellow.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
leds  input  3  light bus from traffic_light: [2]=green, [1]=yellow, [0]=red
err_clr  input  1  synchronous clear of sticky error bits
phase  output  3  current decoded phase: 0 OFF, 1 GREEN, 2 YELLOW, 3 RED, 4 ILLEGAL
phase_done  output  1  one-cycle pulse: a phase just ended
last_phase  output  3  code of the phase that ended; valid while phase_done=1, held otherwise
phase_len  output  CNT_W  length of the ended phase in cycles; updated with phase_done
err  output  3  sticky errors: [0] illegal encoding, [1] illegal order, [2] timing violation

Behaviour:
- Decode: 000→OFF, 100→GREEN, 010→YELLOW, 001→RED, any other value→ILLEGAL.
- Reset (async, immediate):
  - phase=0, phase_done=0, last_phase=0, phase_len=0, err=000.
  - Internal cnt=0; internal "checked" flag=0.
- Each posedge, with d = decode(leds):
  - d == phase: cnt ← cnt+1, saturating at 2^CNT_W-1.
  - d != phase (phase end):
    - phase ← d; cnt ← 1.
    - phase_done ← 1; last_phase ← old phase; phase_len ← old cnt.
    - checked ← 1 only if old phase ∈ {GREEN, YELLOW, RED}; else 0.
  - Otherwise phase_done ← 0.
  - All outputs registered: a change on leds is visible one cycle later.
- First phase after reset: cnt counts from the first posedge, so a phase held N cycles after reset reports phase_len=N.
- Legal transitions (no order error):
  - GREEN→YELLOW, GREEN→RED (force-red), YELLOW→RED, RED→GREEN.
  - Any→OFF, OFF→any legal code.
  - ILLEGAL→any.
- err[1] set on GREEN→… excluded above (none remain), YELLOW→GREEN, RED→YELLOW.
- err[0] set on any transition into ILLEGAL, and every cycle phase==ILLEGAL.
- Timing checks are evaluated at phase end and only when checked=1 for the ending phase. Violations set err[2]:
  - YELLOW entered from GREEN: length must be exactly YELLOW_CYC.
  - RED ending into GREEN: length must be ≥ RED_CYC.
  - GREEN ending into YELLOW: length must be within GREEN_MIN_CYC..GREEN_MAX_CYC.
  - GREEN ending into RED: no check (force-red).
- Attention blink (alternating 000/010): no order error. Yellow entered from OFF is unchecked.
- Saturated green (cnt=max) still fails the max check.
- err_clr: clears err next cycle. If an error event occurs in the same cycle, the set wins for that bit.
- Reset mid-phase: all state cleared at once; the interrupted phase is never reported.

Test Plan:
1. Reset, then green 61 → yellow 7 → red 5 → green. Expect phase_done pulses with (last_phase, phase_len) = (1,61), (2,7), (3,5), and err=000.
2. Green 61 → yellow 6 → red. Expect err=100 (bit 2) one cycle after yellow ends; err_clr next cycle → err=000.
3. leds=110 for 1 cycle mid-green. Expect phase=4 and err[0]=1. The following green→… sequence produces no order error.
4. Red 5 → yellow. Expect err[1]=1. Yellow 61 → green. Expect an additional order error, and no timing error because yellow was entered from red, not green.
5. Reset, green 2 cycles, then red 5. Expect no error (force-red). Then blink 000×3 / 010×3 twice. Expect phase_done each 3 cycles, phase_len=3, err=000.
6. Assert rst asynchronously between clock edges during yellow. Expect all outputs 0 before the next posedge. Also apply err_clr=1 together with leds=011. Expect err[0]=1.
